sobel_window_builder: RTL and testbench
=======================================

# sobel_window_builder

Front end of the Sobel pipeline. Accepts a raster-scan 8-bit grayscale pixel stream and buffers the two previous image rows. Assembles a registered 3x3 neighbourhood for every interior pixel. Presents that neighbourhood as `windowBuffer[0:8]` with a one-cycle `start_calculations` strobe, which is the exact input contract of `horizontal_gradient` and the vertical/total gradient blocks.

## Interface
Parameters:
- `IMG_WIDTH`, 640: pixels per row. Must be ≥ 3.
- `IMG_HEIGHT`, 480: rows per frame. Must be ≥ 3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_in`  in  8  incoming pixel, unsigned.
- `pixel_valid`  in  1  `pixel_in` is accepted on this edge.
- `frame_start`  in  1  qualifies the accepted pixel as pixel (0,0) of a new frame. Ignored when `pixel_valid` = 0.
- `windowBuffer`  out  [7:0] x 9 (`[0:8]`)  registered 3x3 window, row-major. Index 0 is top-left (oldest row, leftmost column). Index 8 is bottom-right (newest pixel).
- `start_calculations`  out  1  one-cycle pulse: `windowBuffer` holds a new valid window.
- `center_col`  out  `$clog2(IMG_WIDTH)`  column of the window centre.
- `center_row`  out  `$clog2(IMG_HEIGHT)`  row of the window centre.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Internal counters `col`/`row` give the position of the next pixel to be accepted. `pixel_valid` = 0 stalls: no state changes and outputs hold.
- Accepted pixel with `frame_start` = 1 is forced to position (0,0), regardless of the counters. This is how a new frame is begun mid-frame: the partial frame is abandoned and no partial-frame window is produced.
- Two line buffers, `IMG_WIDTH` deep, indexed by `col`. `lb1` holds row r-1 and `lb0` holds row r-2.
- On accept at column c:
  - Read `lb0[c]` and `lb1[c]`.
  - Write `lb0[c] <= lb1[c]` and `lb1[c] <= pixel_in`. Read returns the old value (read-before-write).
- Window shift: columns shift left (index 0/3/6 <- 1/4/7 <- 2/5/8). The new right column is {`lb0[c]`, `lb1[c]`, `pixel_in`}, written to indices 2, 5 and 8.
- A window is valid when the accept is at row ≥ 2 and col ≥ 2. Otherwise `windowBuffer` still shifts, but `start_calculations` stays 0.
- Windows never straddle a row boundary: the col ≥ 2 gate discards the first two shifts of each row.
- Each frame produces (`IMG_WIDTH`-2)*(`IMG_HEIGHT`-2) strobes.
- `center_col`/`center_row` are registered with the window as `col`-1 and `row`-1.
- Counter wrap:
  - `col` = `IMG_WIDTH`-1 -> `col` = 0 and `row`++.
  - Last pixel (`IMG_WIDTH`-1, `IMG_HEIGHT`-1) -> `row` = 0, `col` = 0, `frame_done` pulses.
  - A following frame may start without `frame_start`.
- Reset values:
  - `windowBuffer` all 0, `start_calculations` 0, `frame_done` 0, `center_col`/`center_row` 0.
  - Internal counters 0.
  - Line buffers are not reset. Stale contents are unobservable because of the row ≥ 2 gate.
- `rst` mid-frame: all of the above apply on the next edge. `rst` has priority over `pixel_valid`.

## Timing
- Latency is 1 cycle. A pixel accepted on edge k updates `windowBuffer`, `center_*` and `start_calculations` after edge k.
- Window registers and the strobe update on the same edge, so `start_calculations` = 1 always coincides with the matching window.
- `windowBuffer` holds until the next accept, so downstream combinational gradients may sample on the strobe cycle or any later stall cycle.
- Throughput is one pixel per cycle. Back-to-back `pixel_valid` gives back-to-back strobes within a row.
- `frame_done` is asserted in the same cycle as the strobe for the final window.

## Structure
- Shared `sobel_pkg`:
  - `PIX_W` = 8.
  - `pixel_t` = logic [7:0].
  - `window_t` = pixel_t [0:8].
  - Window index constants `WIN_TL` = 0 … `WIN_BR` = 8.
  - `GRAD_W` = 11.
- Sub-module `sobel_line_buffer` (parameter `DEPTH`): single-port, read-before-write, one write per accept. Instantiated twice.
- Top level holds the counters, window shift registers and strobe logic.

## Test plan
Use `IMG_WIDTH` = 4 and `IMG_HEIGHT` = 4. The image is `pixel_in` = 10*row+col.
- Reset, then stream a full frame with `pixel_valid` held high:
  - Expect exactly 4 strobes, at the accepts of (2,2), (2,3), (3,2) and (3,3).
  - First window is {0,1,2,10,11,12,20,21,22} with centre (1,1).
  - Last window is {11,12,13,21,22,23,31,32,33} with centre (2,2).
  - `frame_done` pulses with the 4th strobe.
- Stream rows {50,255,250,x}, {100,0,200,x}, {100,255,255,x}, where x is don't-care:
  - First strobe window is {50,255,250,100,0,200,100,255,255}.
  - A connected `horizontal_gradient` gives `gx` = 555.
- Same frame with `pixel_valid` low for 3 cycles between every pixel:
  - Identical windows and strobe count.
  - `windowBuffer` is constant during every stall.
- Reset asserted after pixel (2,1), then a fresh frame with `frame_start`:
  - All outputs read 0 the cycle after reset.
  - No strobe until (2,2) of the new frame.
  - The window matches the clean-frame case.
- `frame_start` on the accept of position (3,0) of an in-progress frame:
  - Counters restart at (0,0).
  - The next strobe is at new (2,2) with window {0,1,2,10,11,12,20,21,22}.
- Two frames back-to-back without `frame_start` on the second:
  - 8 strobes and 2 `frame_done` pulses.
  - Second-frame windows equal first-frame windows.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pipeline.
// Defines the pixel and 3x3 window types, the window index map and the window column shift.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [0:8]     window_t;

  // Row-major window positions: top row is the oldest image row
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic window_t window_shift(
    input window_t w,
    input pixel_t  top,
    input pixel_t  mid,
    input pixel_t  bot
  );
    window_t n;
    n[WIN_TL] = w[WIN_TC];
    n[WIN_TC] = w[WIN_TR];
    n[WIN_TR] = top;
    n[WIN_ML] = w[WIN_MC];
    n[WIN_MC] = w[WIN_MR];
    n[WIN_MR] = mid;
    n[WIN_BL] = w[WIN_BC];
    n[WIN_BC] = w[WIN_BR];
    n[WIN_BR] = bot;
    return n;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage, addressed by column.
// Asynchronous read returns the old entry on the same edge a new one is written.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  pixel_t                   wr_data,
  output pixel_t                   rd_data
);

  pixel_t mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Row storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_builder.sv
// Builds a registered 3x3 neighbourhood from a raster pixel stream using two line buffers.
// Strobes start_calculations for every interior window and frame_done after the last pixel.
module sobel_window_builder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  pixel_t                        pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output window_t                       windowBuffer,
  output logic                          start_calculations,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_row,
  output logic                          frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] acc_col_s;
  logic [ROW_W-1:0] acc_row_s;
  logic             last_col_s;
  logic             last_row_s;
  logic             win_ok_s;
  logic             lb_we_s;
  pixel_t           lb0_rd_s;
  pixel_t           lb1_rd_s;

  window_t          win_r;
  logic             start_r;
  logic             done_r;
  logic [COL_W-1:0] center_col_r;
  logic [ROW_W-1:0] center_row_r;

  // frame_start forces the accepted pixel to (0,0), abandoning any partial frame
  assign acc_col_s  = frame_start ? '0 : col_r;
  assign acc_row_s  = frame_start ? '0 : row_r;
  assign last_col_s = (acc_col_s == COL_W'(IMG_WIDTH - 1));
  assign last_row_s = (acc_row_s == ROW_W'(IMG_HEIGHT - 1));
  assign win_ok_s   = (acc_row_s >= ROW_W'(2)) && (acc_col_s >= COL_W'(2));
  assign lb_we_s    = pixel_valid && !rst;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (clk),
    .we      (lb_we_s),
    .addr    (acc_col_s),
    .wr_data (lb1_rd_s),
    .rd_data (lb0_rd_s)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .we      (lb_we_s),
    .addr    (acc_col_s),
    .wr_data (pixel_in),
    .rd_data (lb1_rd_s)
  );

  // Position counters, window shift and strobes; pulses drop on stall cycles while the window holds
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r        <= '0;
      row_r        <= '0;
      win_r        <= '0;
      start_r      <= 1'b0;
      done_r       <= 1'b0;
      center_col_r <= '0;
      center_row_r <= '0;
    end else if (pixel_valid) begin
      win_r        <= window_shift(win_r, lb0_rd_s, lb1_rd_s, pixel_in);
      start_r      <= win_ok_s;
      done_r       <= last_col_s && last_row_s;
      center_col_r <= acc_col_s - COL_W'(1);
      center_row_r <= acc_row_s - ROW_W'(1);
      if (last_col_s) begin
        col_r <= '0;
        row_r <= last_row_s ? '0 : acc_row_s + ROW_W'(1);
      end else begin
        col_r <= acc_col_s + COL_W'(1);
        row_r <= acc_row_s;
      end
    end else begin
      start_r <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  assign windowBuffer       = win_r;
  assign start_calculations = start_r;
  assign frame_done         = done_r;
  assign center_col         = center_col_r;
  assign center_row         = center_row_r;

endmodule

// File: tb/tb_sobel_window_builder.sv
// Self-checking bench for sobel_window_builder on a 4x4 image.
// A frame-store model predicts each window straight from the image it has been fed.
module tb_sobel_window_builder;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic    clk = 1'b0;
  logic    rst;
  pixel_t  pixel_in;
  logic    pixel_valid;
  logic    frame_start;
  window_t windowBuffer;
  logic    start_calculations;
  logic [$clog2(W)-1:0] center_col;
  logic [$clog2(H)-1:0] center_row;
  logic    frame_done;

  sobel_window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                (clk),
    .rst                (rst),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .frame_start        (frame_start),
    .windowBuffer       (windowBuffer),
    .start_calculations (start_calculations),
    .center_col         (center_col),
    .center_row         (center_row),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      img [0:H-1][0:W-1];
  int      mrow = 0;
  int      mcol = 0;
  bit      have_win = 1'b0;
  window_t last_win;
  int      dut_strobes = 0;
  int      dut_dones = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs, then compare against the frame-store model
  task automatic step(input logic v, input logic fs, input pixel_t p);
    bit      exp_strobe;
    bit      exp_done;
    window_t ew;
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = p;
    @(posedge clk);
    #1;
    if (start_calculations === 1'b1) dut_strobes++;
    if (frame_done === 1'b1) dut_dones++;
    if (v) begin
      if (fs) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = int'(p);
      exp_strobe = (mrow >= 2) && (mcol >= 2);
      exp_done   = (mrow == H - 1) && (mcol == W - 1);
      check_eq("strobe", start_calculations, exp_strobe);
      check_eq("frame_done", frame_done, exp_done);
      if (exp_strobe) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew[3*i+j] = pixel_t'(img[mrow-2+i][mcol-2+j]);
        check_eq("window", windowBuffer, ew);
        check_eq("center_col", center_col, mcol - 1);
        check_eq("center_row", center_row, mrow - 1);
        last_win = ew;
        have_win = 1'b1;
      end else begin
        have_win = 1'b0;
      end
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end
    end else begin
      check_eq("stall_strobe", start_calculations, 1'b0);
      check_eq("stall_done", frame_done, 1'b0);
      if (have_win) check_eq("stall_hold", windowBuffer, last_win);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pixel_valid = 1'b1;
    frame_start = 1'b0;
    pixel_in = 8'd99;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pixel_valid = 1'b0;
    check_eq("rst_window", windowBuffer, 72'd0);
    check_eq("rst_strobe", start_calculations, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_center_col", center_col, 2'd0);
    check_eq("rst_center_row", center_row, 2'd0);
    mrow = 0;
    mcol = 0;
    have_win = 1'b0;
  endtask

  task automatic stream_frame(input int gap, input bit fs_first);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, fs_first && (r == 0) && (c == 0), pixel_t'(10 * r + c));
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, pixel_t'($urandom));
      end
  endtask

  initial begin
    int     s0;
    int     d0;
    int     gx;
    pixel_t gx_img [0:H-1][0:W-1];
    rst = 1'b1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in = 8'd0;
    @(posedge clk);
    #1;
    do_reset();

    // clean frame
    s0 = dut_strobes; d0 = dut_dones;
    stream_frame(0, 1'b0);
    check_eq("clean_strobes", dut_strobes - s0, 4);
    check_eq("clean_dones", dut_dones - d0, 1);

    // gradient example frame; last column and row are don't-care
    gx_img[0] = '{8'd50, 8'd255, 8'd250, 8'd0};
    gx_img[1] = '{8'd100, 8'd0, 8'd200, 8'd0};
    gx_img[2] = '{8'd100, 8'd255, 8'd255, 8'd0};
    for (int r = 0; r < H; r++) gx_img[r][W-1] = pixel_t'($urandom);
    for (int c = 0; c < W; c++) gx_img[H-1][c] = pixel_t'($urandom);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'b0, gx_img[r][c]);
        if (r == 2 && c == 2) begin
          gx = (int'(windowBuffer[2]) + 2 * int'(windowBuffer[5]) + int'(windowBuffer[8]))
             - (int'(windowBuffer[0]) + 2 * int'(windowBuffer[3]) + int'(windowBuffer[6]));
          check_eq("gx", gx, 555);
        end
      end

    // stalled frame
    s0 = dut_strobes; d0 = dut_dones;
    stream_frame(3, 1'b0);
    check_eq("stall_strobes", dut_strobes - s0, 4);
    check_eq("stall_dones", dut_dones - d0, 1);

    // reset after pixel (2,1), then fresh frame
    s0 = dut_strobes;
    for (int k = 0; k < 2 * W + 2; k++) step(1'b1, 1'b0, pixel_t'(10 * (k / W) + k % W));
    check_eq("pre_rst_strobes", dut_strobes - s0, 0);
    do_reset();
    s0 = dut_strobes;
    stream_frame(0, 1'b1);
    check_eq("post_rst_strobes", dut_strobes - s0, 4);

    // frame_start on the accept of (3,0)
    for (int k = 0; k < 3 * W; k++) step(1'b1, k == 0, pixel_t'(10 * (k / W) + k % W));
    s0 = dut_strobes; d0 = dut_dones;
    step(1'b1, 1'b1, 8'd0);
    check_eq("restart_center_col", center_col, 2'd3);
    for (int k = 1; k < W * H; k++) step(1'b1, 1'b0, pixel_t'(10 * (k / W) + k % W));
    check_eq("restart_strobes", dut_strobes - s0, 4);
    check_eq("restart_dones", dut_dones - d0, 1);

    // two frames back to back, second without frame_start
    s0 = dut_strobes; d0 = dut_dones;
    stream_frame(0, 1'b1);
    stream_frame(0, 1'b0);
    check_eq("b2b_strobes", dut_strobes - s0, 8);
    check_eq("b2b_dones", dut_dones - d0, 2);

    // random traffic with occasional restarts
    for (int k = 0; k < 400; k++) begin
      logic v;
      v = ($urandom_range(9) < 7);
      step(v, v && ($urandom_range(29) == 0), pixel_t'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
